onchip_mem_stream_loader: RTL and testbench
===========================================

# onchip_mem_stream_loader

Streaming loader that sits directly upstream of the 32-bit single-port on-chip RAM (13-bit word address, 7741 words, 1-cycle read latency). It accepts words on an Avalon-ST sink and writes them to consecutive RAM addresses from a programmed base. It then reads the region back and checks a modulo-2^32 sum, so firmware can confirm a buffer was loaded intact before the Nios core uses it.

## Interface
Parameters:
- ADDR_W, 13, RAM word-address width
- DATA_W, 32, word width
- DEPTH, 7741, RAM words; highest legal address is DEPTH-1

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  load request, sampled only in IDLE
- base_addr  in  ADDR_W  first RAM word address, sampled with start
- word_count  in  ADDR_W  words to load, sampled with start
- sink_data  in  DATA_W  stream word
- sink_valid  in  1  stream word valid
- sink_ready  out  1  loader accepts a word
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  4  always 4'hF
- mem_chipselect  out  1  RAM access this cycle
- mem_write  out  1  write strobe, qualified by chipselect
- mem_writedata  out  DATA_W  write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after the address
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky until the next accepted start
- err_code  out  2  0 none, 1 range, 2 verify mismatch
- checksum  out  DATA_W  sum of written words, held until the next start

## Operation
- Reset values:
  - sink_ready, mem_chipselect, mem_write, mem_clken, busy, done, error = 0.
  - mem_address, mem_writedata, err_code, checksum = 0.
  - mem_byteenable = 4'hF.
  - State = IDLE.
- mem_clken is 1 whenever reset_n is high.
- **IDLE**: on start=1, latch base_addr and word_count, clear error, err_code and checksum, then:
  - word_count==0 or base_addr+word_count > DEPTH (evaluated at ADDR_W+1 bits): go to FAIL with err_code=1. No RAM access is issued.
  - Otherwise go to FILL with idx=0.
- **FILL**:
  - sink_ready=1 while idx < word_count.
  - A beat is accepted when sink_valid & sink_ready.
  - Each accepted beat produces a registered write on the next cycle: mem_chipselect=1, mem_write=1, mem_address=base+idx, mem_writedata=sink_data. In the same step checksum += sink_data (wraps mod 2^32) and idx increments.
  - sink_ready drops in the cycle after the last beat is accepted.
  - Stalls of sink_valid insert idle cycles (chipselect=0) and have no other effect.
  - Once the last write has been issued, go to VERIFY with ridx=0 and vsum=0.
- **VERIFY**:
  - Issue one read per cycle: chipselect=1, write=0, address=base+ridx, for ridx = 0..word_count-1, with no gaps.
  - Capture mem_readdata one cycle after each address and add it to vsum.
  - After the last capture, go to CHECK.
- **CHECK** (1 cycle): if vsum != checksum, set err_code=2 and error=1. Go to DONE.
- **FAIL** (1 cycle): set error=1, then go to DONE.
- **DONE** (1 cycle): done=1, busy=0 from the next cycle, return to IDLE.
- start while not IDLE is ignored.
- sink_ready=0 outside FILL; words presented then are not consumed.
- Addresses never wrap. The range check guarantees base+idx ≤ DEPTH-1.
- Reset mid-operation: outputs return to reset values asynchronously. Words already written stay in RAM. Any partially presented beat is not consumed.

## Timing
- start accepted at edge E0. busy=1 and sink_ready=1 from the cycle after E0.
- Continuous sink_valid, N words:
  - Beat i is accepted at edge E1+i.
  - Write i is on the bus in the cycle after E1+i.
  - Read addresses occupy N consecutive cycles, starting the cycle after the last write.
  - Read data is captured one cycle after each address.
  - CHECK follows the last capture, then DONE.
- Total from start edge to done pulse = 2N+4 cycles with no stalls.
- Range-error path: done pulses 2 cycles after the start edge; no mem_chipselect ever.

## Test plan
- Load base=0, count=4, words 1,2,3,4 with continuous valid:
  - Writes go to addresses 0..3, then reads to 0..3.
  - checksum=10, error=0, done pulse 12 cycles after start.
- base=7737, count=4 (last legal span) -> addresses 7737..7740 written and verified, no error. base=7738, count=4 -> err_code=1, done at +2, no chipselect.
- count=0 -> err_code=1, no RAM access, sink_ready never asserted.
- Bench model corrupts the readback word at base+1 during VERIFY -> err_code=2, error=1, and checksum still equals the written sum.
- Random sink_valid gaps with count=16 and words 0xFFFFFFFF -> checksum=0xFFFFFFF0 (wrap), no error, writes only on accepted beats.
- reset_n asserted after 2 of 8 beats, then released and a fresh start issued -> all outputs zero during reset; second load completes normally and done pulses exactly once.

Source files
------------

// File: rtl/onchip_mem_stream_loader.sv
// onchip_mem_stream_loader
//   Writes a stream of words into the on-chip RAM at consecutive addresses,
//   starting at a programmed base. It then reads the same region back and
//   compares the modulo-2^32 sum of the read words with the sum of the written
//   words.
//
// Ports
//   clk, reset_n        : clock (rising edge) and asynchronous active-low reset
//   start               : load request, sampled only while idle
//   base_addr           : first RAM word address, sampled with start
//   word_count          : number of words to load, sampled with start
//   sink_data           : Avalon-ST sink data
//   sink_valid          : Avalon-ST sink valid
//   sink_ready          : Avalon-ST sink ready
//   mem_address         : RAM word address
//   mem_byteenable      : RAM byte enables (always all lanes)
//   mem_chipselect      : RAM access this cycle
//   mem_write           : write strobe, qualified by mem_chipselect
//   mem_writedata       : RAM write data
//   mem_clken           : RAM clock enable
//   mem_readdata        : RAM read data, valid the cycle after the address
//   busy                : loader not idle
//   done                : one-cycle completion pulse
//   error               : sticky error flag, cleared by the next accepted start
//   err_code            : 0 none, 1 range, 2 verify mismatch
//   checksum            : sum of written words, held until the next start
module onchip_mem_stream_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 7741
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [DATA_W-1:0] sink_data,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_VERIFY, S_CHECK, S_FAIL, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;     // beats accepted
  logic [ADDR_W-1:0]   ridx_q, ridx_d;   // read addresses issued
  logic [ADDR_W-1:0]   cap_q, cap_d;     // read words captured
  logic                rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]   vsum_q, vsum_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                sink_ready_q, sink_ready_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;

  // End of the requested span, one bit wider so it cannot wrap.
  logic [ADDR_W:0]     span_end;
  assign span_end = {1'b0, base_addr} + {1'b0, word_count};

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    idx_d        = idx_q;
    ridx_d       = ridx_q;
    cap_d        = cap_q;
    vsum_d       = vsum_q;
    checksum_d   = checksum_q;
    sink_ready_d = sink_ready_q;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    // A read address on the bus this cycle means read data arrives next cycle.
    rd_pipe_d    = cs_q & ~we_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          idx_d      = '0;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          checksum_d = '0;
          if (word_count == '0 || span_end > DEPTH_L) begin
            state_d    = S_FAIL;
            err_code_d = 2'd1;
          end else begin
            state_d      = S_FILL;
            sink_ready_d = 1'b1;
          end
        end
      end

      S_FILL: begin
        if (idx_q == count_q) begin
          // Last write is on the bus now; the first read follows directly.
          state_d = S_VERIFY;
          cs_d    = 1'b1;
          addr_d  = base_q;
          ridx_d  = ADDR_W'(1);
          cap_d   = '0;
          vsum_d  = '0;
        end else if (sink_valid && sink_ready_q) begin
          cs_d         = 1'b1;
          we_d         = 1'b1;
          addr_d       = base_q + idx_q;
          wdata_d      = sink_data;
          checksum_d   = checksum_q + sink_data;
          idx_d        = idx_q + 1'b1;
          sink_ready_d = (idx_q + 1'b1) < count_q;
        end
      end

      S_VERIFY: begin
        if (ridx_q < count_q) begin
          cs_d   = 1'b1;
          addr_d = base_q + ridx_q;
          ridx_d = ridx_q + 1'b1;
        end
        if (rd_pipe_q) begin
          vsum_d = vsum_q + mem_readdata;
          cap_d  = cap_q + 1'b1;
          if (cap_q == count_q - 1'b1) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (vsum_q != checksum_q) begin
          err_code_d = 2'd2;
          error_d    = 1'b1;
        end
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      ridx_q       <= '0;
      cap_q        <= '0;
      rd_pipe_q    <= 1'b0;
      vsum_q       <= '0;
      checksum_q   <= '0;
      sink_ready_q <= 1'b0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      ridx_q       <= ridx_d;
      cap_q        <= cap_d;
      rd_pipe_q    <= rd_pipe_d;
      vsum_q       <= vsum_d;
      checksum_q   <= checksum_d;
      sink_ready_q <= sink_ready_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign sink_ready     = sink_ready_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = 4'hF;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  // RAM clock runs whenever the loader is out of reset.
  assign mem_clken      = reset_n;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Bench for onchip_mem_stream_loader: a RAM model with optional readback
// corruption, directed loads, and a per-cycle compare process driven by a
// high-level model (expected write list, read window, done time, sums).
module tb_onchip_mem_stream_loader;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 7741;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic [DW-1:0] sink_data = '0;
  logic          sink_valid = 1'b0;
  logic          sink_ready;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  onchip_mem_stream_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_ready(sink_ready), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .checksum(checksum)
  );

  // RAM model: 1-cycle read latency; optionally flips bit 0 of one address on readback.
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] ram_rd = '0;
  int            corrupt_addr = -1;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      else ram_rd <= ram[mem_address] ^ ((int'(mem_address) == corrupt_addr) ? 32'h1 : 32'h0);
    end
  end
  assign mem_readdata = ram_rd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Test configuration written by the stimulus.
  bit          m_active = 1'b0;
  int          m_base, m_count, m_e0;
  bit          lit_sum_en;
  logic [31:0] lit_sum;
  int          lit_off;
  logic [31:0] words [0:31];

  // Model state owned by the compare process.
  int          d_wr_seen, d_rd_start, d_exp_done, d_acc, d_done_cnt;
  logic [31:0] d_sum, d_pend_data;
  bit          d_pend, prev_active;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    d_wr_seen = 0; d_rd_start = 0; d_exp_done = 0; d_acc = 0; d_done_cnt = 0;
    d_sum = '0; d_pend = 1'b0; d_pend_data = '0;
  endtask

  // Compare process: every cycle, sampled at the falling edge.
  initial begin
    bit rng, is_wr, is_rd, exp_rd, exp_busy, exp_ready, exp_done;
    int code;
    clear_model();
    prev_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset_outputs",
            128'({sink_ready, mem_chipselect, mem_write, mem_clken, busy, done, error,
                  err_code, mem_address, mem_writedata, checksum, mem_byteenable}),
            128'(4'hF));
        clear_model();
        prev_active = 1'b0;
      end else if (!m_active) begin
        if (prev_active) chk("done_count", 128'(d_done_cnt), 128'(1));
        chk("idle_outputs", 128'({busy, sink_ready, mem_chipselect, done}), 128'(0));
        chk("clken", 128'(mem_clken), 128'(1));
        clear_model();
        prev_active = 1'b0;
      end else begin
        prev_active = 1'b1;
        rng = (m_count == 0) || (m_base + m_count > DEPTH);
        if (rng && d_exp_done == 0) d_exp_done = m_e0 + 1;
        chk("byteenable", 128'(mem_byteenable), 128'(4'hF));
        is_wr = mem_chipselect && mem_write;
        is_rd = mem_chipselect && !mem_write;
        // A write appears exactly in the cycle after each accepted beat.
        chk("write_strobe", 128'(is_wr), 128'(d_pend));
        if (is_wr && d_pend) begin
          chk("wr_addr", 128'(mem_address), 128'(m_base + d_wr_seen));
          chk("wr_data", 128'(mem_writedata), 128'(d_pend_data));
          d_sum = d_sum + d_pend_data;
          d_wr_seen++;
          if (d_wr_seen == m_count) begin
            d_rd_start = cyc + 1;
            d_exp_done = cyc + m_count + 3;
          end
        end
        exp_rd = (d_rd_start != 0) && (cyc >= d_rd_start) && (cyc < d_rd_start + m_count);
        chk("read_strobe", 128'(is_rd), 128'(exp_rd));
        if (exp_rd && is_rd) chk("rd_addr", 128'(mem_address), 128'(m_base + cyc - d_rd_start));
        exp_busy  = (cyc >= m_e0) && (d_exp_done == 0 || cyc <= d_exp_done);
        exp_ready = !rng && (cyc >= m_e0) && (d_acc < m_count);
        exp_done  = (d_exp_done != 0) && (cyc == d_exp_done);
        chk("busy", 128'(busy), 128'(exp_busy));
        chk("sink_ready", 128'(sink_ready), 128'(exp_ready));
        chk("done", 128'(done), 128'(exp_done));
        if (done) begin
          d_done_cnt++;
          code = rng ? 1 : ((corrupt_addr >= 0) ? 2 : 0);
          chk("checksum", 128'(checksum), 128'(d_sum));
          chk("err_code", 128'(err_code), 128'(code));
          chk("error", 128'(error), 128'(code != 0));
          if (lit_sum_en) chk("lit_checksum", 128'(checksum), 128'(lit_sum));
          if (lit_off >= 0) chk("lit_done_offset", 128'(cyc + 1 - m_e0), 128'(lit_off));
        end
        d_pend      = sink_valid && sink_ready;
        d_pend_data = sink_data;
        if (d_pend) d_acc++;
      end
    end
  end

  task automatic issue_start(input int b, input int n);
    @(posedge clk); #1;
    m_base = b; m_count = n; m_e0 = cyc + 1; m_active = 1'b1;
    base_addr = b[AW-1:0]; word_count = n[AW-1:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds beats 0..upto-1 following the valid pattern; optionally pulses a
  // stray start mid-fill, which the loader must ignore.
  task automatic feed(input int upto, input logic [63:0] pat, input bit inject);
    int  k, t, guard;
    bit  will;
    k = 0; t = 0; guard = 0;
    while (k < upto && guard < 1000) begin
      sink_valid = pat[t[5:0]];
      sink_data  = words[k];
      start      = inject && (t == 5);
      if (start) begin base_addr = '0; word_count = 1; end
      t++;
      @(negedge clk);
      will = sink_valid && sink_ready;
      @(posedge clk); #1;
      if (will) k++;
      guard++;
    end
    start = 1'b0;
  endtask

  task automatic run_load(input int b, input int n, input logic [63:0] pat, input int corrupt,
                          input bit lsum_en, input logic [31:0] lsum, input int loff, input bit inject);
    int guard;
    corrupt_addr = corrupt; lit_sum_en = lsum_en; lit_sum = lsum; lit_off = loff;
    issue_start(b, n);
    if (n > 0 && b + n <= DEPTH) feed(n, pat, inject);
    else sink_valid = 1'b1;  // words offered while not filling must not be taken
    guard = 0;
    while (d_done_cnt == 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    sink_valid = 1'b0; sink_data = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("load base=%0d count=%0d checksum=%0h err_code=%0d done_seen=%0d",
             b, n, checksum, err_code, d_done_cnt);
    m_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 4; i++) words[i] = 32'(i + 1);
    run_load(0, 4, '1, -1, 1'b1, 32'd10, 12, 1'b0);

    for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
    run_load(7737, 4, '1, -1, 1'b1, 32'h286, 12, 1'b0);
    run_load(7738, 4, '1, -1, 1'b1, 32'h0, 2, 1'b0);
    run_load(5, 0, '1, -1, 1'b1, 32'h0, 2, 1'b0);

    words[0] = 32'd5; words[1] = 32'd6; words[2] = 32'd7;
    run_load(100, 3, '1, 101, 1'b1, 32'd18, 10, 1'b0);

    for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
    run_load(300, 16, 64'hB5A3_96D2_71E4_C3A5, -1, 1'b1, 32'hFFFF_FFF0, -1, 1'b1);

    // Reset after two of eight beats, then a fresh complete load.
    for (int i = 0; i < 8; i++) words[i] = 32'h100 + 32'(i + 1);
    corrupt_addr = -1; lit_sum_en = 1'b0; lit_off = -1;
    issue_start(200, 8);
    feed(2, '1, 1'b0);
    sink_valid = 1'b1;
    reset_n = 1'b0;
    m_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sink_valid = 1'b0;
    reset_n = 1'b1;
    $display("reset applied mid-load base=200 count=8");
    repeat (2) @(posedge clk);
    #1;
    run_load(200, 8, '1, -1, 1'b1, 32'h824, 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
